// File: rtl/inst_mem.sv
`default_nettype none
// ============================================================================
// Module   : inst_mem
// Brief    : Byte-loaded instruction store with a one-cycle fetch port.
// Revision : 1.0
// ============================================================================
module inst_mem #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_load_valid,
    input  logic [7:0]                     i_load_byte,
    output logic                           o_load_ready,
    input  logic                           i_load_done,
    input  logic [31:0]                    i_pc,
    output logic [31:0]                    o_inst,
    output logic                           o_inst_valid,
    output logic                           o_misaligned,
    output logic                           o_out_of_range,
    output logic [$clog2(DEPTH_WORDS):0]   o_word_count
);

    localparam int                 c_AW    = $clog2(DEPTH_WORDS);
    localparam logic [c_AW:0]      c_DEPTH = (c_AW+1)'(DEPTH_WORDS);
    localparam logic [c_AW:0]      c_ONE   = (c_AW+1)'(1);

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [1:0]        r_lane;
    logic [c_AW:0]     r_word_count;
    logic [31:0]       r_buf;
    logic [31:0]       r_mem [DEPTH_WORDS];
    logic [31:0]       r_rd_data;
    logic              r_inst_valid;
    logic              r_misaligned;
    logic              r_out_of_range;

    logic              w_load_ready;
    logic              w_accept;
    logic              w_done;
    logic              w_write;
    logic [1:0]        w_lane_next;
    logic [31:0]       w_buf_next;
    logic              w_mis;
    logic              w_oor;
    logic [c_AW-1:0]   w_rd_idx;

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_LOAD: if (i_load_done) w_state_next = ST_RUN;
            ST_RUN:  w_state_next = ST_RUN;
            default: w_state_next = ST_LOAD;
        endcase
    end

    // ------------------------------------------------------------------
    // Loader: bytes assemble into r_buf, which is cleared after every
    // word write so unfilled upper lanes of a partial word read as zero.
    // ------------------------------------------------------------------
    assign w_load_ready = (r_state == ST_LOAD) && (r_word_count < c_DEPTH);
    assign w_accept     = i_load_valid && w_load_ready;
    assign w_done       = i_load_done && (r_state == ST_LOAD);
    assign w_lane_next  = w_accept ? (r_lane + 2'd1) : r_lane;

    always_comb begin
        w_buf_next = r_buf;
        if (w_accept) begin
            w_buf_next[{r_lane, 3'b000} +: 8] = i_load_byte;
        end
    end

    // A full word and a trailing partial are mutually exclusive, so a word
    // completed together with LOAD_DONE is written exactly once.
    assign w_write = (w_accept && (r_lane == 2'd3)) ||
                     (w_done && (w_lane_next != 2'd0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane       <= 2'd0;
            r_word_count <= '0;
            r_buf        <= 32'd0;
        end else if (w_write) begin
            r_lane       <= 2'd0;
            r_word_count <= r_word_count + c_ONE;
            r_buf        <= 32'd0;
        end else begin
            r_lane       <= w_lane_next;
            r_buf        <= w_buf_next;
        end
    end

    // ------------------------------------------------------------------
    // Storage and fetch
    // ------------------------------------------------------------------
    assign w_mis    = |i_pc[1:0];
    assign w_oor    = !w_mis &&
                      (i_pc[31:2] >= {{(30-c_AW-1){1'b0}}, r_word_count});
    assign w_rd_idx = i_pc[c_AW+1:2];

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_word_count[c_AW-1:0]] <= w_buf_next;
        end
        r_rd_data <= r_mem[w_rd_idx];
    end

    always_ff @(posedge clk) begin
        if (rst || (r_state != ST_RUN)) begin
            r_inst_valid   <= 1'b0;
            r_misaligned   <= 1'b0;
            r_out_of_range <= 1'b0;
        end else begin
            r_inst_valid   <= 1'b1;
            r_misaligned   <= w_mis;
            r_out_of_range <= w_oor;
        end
    end

    assign o_inst         = (r_inst_valid && !r_misaligned && !r_out_of_range)
                            ? r_rd_data : NOP_WORD;
    assign o_inst_valid   = r_inst_valid;
    assign o_misaligned   = r_misaligned;
    assign o_out_of_range = r_out_of_range;
    assign o_load_ready   = w_load_ready;
    assign o_word_count   = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_inst_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_mem
// Brief    : Directed, table-driven bench for inst_mem (depth 256 and 4).
// Revision : 1.0
// ============================================================================
module tb_inst_mem;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_load_valid = 1'b0;
    logic [7:0]  i_load_byte = 8'd0;
    logic        i_load_done = 1'b0;
    logic [31:0] i_pc = 32'd0;

    logic        o_load_ready, o_inst_valid, o_misaligned, o_out_of_range;
    logic [31:0] o_inst;
    logic [8:0]  o_word_count;

    logic        s_load_ready, s_inst_valid, s_misaligned, s_out_of_range;
    logic [31:0] s_inst;
    logic [2:0]  s_word_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    inst_mem #(.DEPTH_WORDS(256), .NOP_WORD(c_NOP)) dut (
        .clk(clk), .rst(rst),
        .i_load_valid(i_load_valid), .i_load_byte(i_load_byte),
        .o_load_ready(o_load_ready), .i_load_done(i_load_done),
        .i_pc(i_pc), .o_inst(o_inst), .o_inst_valid(o_inst_valid),
        .o_misaligned(o_misaligned), .o_out_of_range(o_out_of_range),
        .o_word_count(o_word_count)
    );

    inst_mem #(.DEPTH_WORDS(4), .NOP_WORD(c_NOP)) dut_small (
        .clk(clk), .rst(rst),
        .i_load_valid(i_load_valid), .i_load_byte(i_load_byte),
        .o_load_ready(s_load_ready), .i_load_done(i_load_done),
        .i_pc(i_pc), .o_inst(s_inst), .o_inst_valid(s_inst_valid),
        .o_misaligned(s_misaligned), .o_out_of_range(s_out_of_range),
        .o_word_count(s_word_count)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        mis;
        logic        oor;
    } fetch_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_load_valid = 1'b0;
        i_load_done  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic done);
        i_load_valid = 1'b1;
        i_load_byte  = b;
        i_load_done  = done;
        tick();
        i_load_valid = 1'b0;
        i_load_done  = 1'b0;
    endtask

    task automatic send_done();
        i_load_done = 1'b1;
        tick();
        i_load_done = 1'b0;
    endtask

    task automatic fetch(input string name, input logic [31:0] pc, input logic [31:0] exp_inst,
                         input logic exp_mis, input logic exp_oor);
        i_pc = pc;
        tick();
        chk({name, "_inst"}, o_inst, exp_inst);
        chk({name, "_mis"},  32'(o_misaligned), 32'(exp_mis));
        chk({name, "_oor"},  32'(o_out_of_range), 32'(exp_oor));
        chk({name, "_valid"}, 32'(o_inst_valid), 32'd1);
    endtask

    fetch_vec_t vecs [7];

    initial begin
        vecs[0] = '{32'h0000_0000, 32'h0010_0513, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0004, 32'h0015_0593, 1'b0, 1'b0};
        vecs[2] = '{32'h0000_0002, c_NOP,         1'b1, 1'b0};
        vecs[3] = '{32'h0000_0008, c_NOP,         1'b0, 1'b1};
        vecs[4] = '{32'h0000_0400, c_NOP,         1'b0, 1'b1};
        vecs[5] = '{32'h0000_0403, c_NOP,         1'b1, 1'b0};
        vecs[6] = '{32'hFFFF_FFFC, c_NOP,         1'b0, 1'b1};

        // Reset state
        do_reset();
        chk("rst_wc",    32'(o_word_count), 32'd0);
        chk("rst_ready", 32'(o_load_ready), 32'd1);
        chk("rst_inst",  o_inst, c_NOP);
        chk("rst_valid", 32'(o_inst_valid), 32'd0);
        chk("rst_flags", {30'd0, o_misaligned, o_out_of_range}, 32'd0);

        // Two full words, then table-driven fetches
        send_byte(8'h13, 1'b0); send_byte(8'h05, 1'b0);
        send_byte(8'h10, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h93, 1'b0); send_byte(8'h05, 1'b0);
        send_byte(8'h15, 1'b0); send_byte(8'h00, 1'b0);
        chk("load_valid_lo", 32'(o_inst_valid), 32'd0);
        send_done();
        chk("two_word_wc",     32'(o_word_count), 32'd2);
        chk("run_ready_lo",    32'(o_load_ready), 32'd0);
        chk("run_entry_valid", 32'(o_inst_valid), 32'd0);
        for (int i = 0; i < 7; i++) begin
            fetch($sformatf("vec%0d", i), vecs[i].pc, vecs[i].inst, vecs[i].mis, vecs[i].oor);
        end
        // Bytes and LOAD_DONE in RUN must be ignored
        send_byte(8'h55, 1'b1);
        chk("run_ignore_wc", 32'(o_word_count), 32'd2);
        fetch("run_ignore_pc8", 32'h8, c_NOP, 1'b0, 1'b1);

        // Partial word zero-filled
        do_reset();
        send_byte(8'h37, 1'b0); send_byte(8'h12, 1'b0);
        send_done();
        chk("partial_wc", 32'(o_word_count), 32'd1);
        fetch("partial_pc0", 32'h0, 32'h0000_1237, 1'b0, 1'b0);
        fetch("partial_pc4", 32'h4, c_NOP, 1'b0, 1'b1);

        // Reset mid-load discards everything
        do_reset();
        for (int i = 0; i < 6; i++) send_byte(8'(8'h40 + i), 1'b0);
        chk("mid_wc_before", 32'(o_word_count), 32'd1);
        do_reset();
        chk("mid_wc_after",    32'(o_word_count), 32'd0);
        chk("mid_valid_after", 32'(o_inst_valid), 32'd0);
        send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0); send_byte(8'hDD, 1'b0);
        send_done();
        chk("reload_wc", 32'(o_word_count), 32'd1);
        fetch("reload_pc0", 32'h0, 32'hDDCC_BBAA, 1'b0, 1'b0);

        // Fourth byte coincident with LOAD_DONE
        do_reset();
        send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b1);
        chk("coinc_wc",    32'(o_word_count), 32'd1);
        chk("coinc_ready", 32'(o_load_ready), 32'd0);
        fetch("coinc_pc0", 32'h0, 32'h0403_0201, 1'b0, 1'b0);
        fetch("coinc_pc4", 32'h4, c_NOP, 1'b0, 1'b1);

        // Depth-4 instance: overflow stream with LOAD_VALID held
        do_reset();
        i_load_valid = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            i_load_byte = 8'(i);
            tick();
            if (i == 15) chk("small_ready_b15", 32'(s_load_ready), 32'd1);
            if (i == 16) begin
                chk("small_ready_b16", 32'(s_load_ready), 32'd0);
                chk("small_wc_b16",    32'(s_word_count), 32'd4);
            end
        end
        i_load_valid = 1'b0;
        chk("small_wc_b20", 32'(s_word_count), 32'd4);
        send_done();
        chk("small_run_wc", 32'(s_word_count), 32'd4);
        i_pc = 32'hC;
        tick();
        chk("small_pc12_inst",  s_inst, 32'h100F_0E0D);
        chk("small_pc12_valid", 32'(s_inst_valid), 32'd1);
        i_pc = 32'h0;
        tick();
        chk("small_pc0_inst", s_inst, 32'h0403_0201);
        i_pc = 32'h10;
        tick();
        chk("small_pc16_inst", s_inst, c_NOP);
        chk("small_pc16_oor",  32'(s_out_of_range), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
